// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART servo command parser.
// Contents:
//   state_e  - parser FSM states
//   SyncByte - frame start marker
//   AckByte  - reply for an accepted frame
//   NackByte - reply for a rejected or aborted frame
//   checksum - 8-bit wrapping sum of id and angle
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StGetId,
    StGetAng,
    StGetCsum,
    StIssue,
    StReply
  } state_e;

  localparam logic [7:0] SyncByte = 8'hFF;
  localparam logic [7:0] AckByte  = 8'h06;
  localparam logic [7:0] NackByte = 8'h15;

  function automatic logic [7:0] checksum(input logic [7:0] id, input logic [7:0] angle);
    return id + angle;
  endfunction

endpackage

// File: rtl/cmd_timeout_timer.sv
// Inter-byte timeout counter.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   clear_i     - synchronous clear, dominates enable
//   enable_i    - count one per cycle while high
//   expired_o   - high while enabled and the count sits at Timeout-1
module cmd_timeout_timer #(
  parameter int unsigned Timeout = 5000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CntW = (Timeout > 1) ? $clog2(Timeout) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Timeout - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != LastCnt)) begin
      // Parks at the terminal value instead of wrapping.
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = enable_i && (cnt_q == LastCnt);

endmodule

// File: rtl/uart_cmd_parser.sv
// Assembles 4-byte servo frames (sync, id, angle, checksum) from UART receive strobes,
// issues validated commands over a valid/ready handshake and answers each completed or
// aborted frame with a single ACK/NACK byte.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   received_i, rx_byte_i - receive strobe and byte
//   recv_error_i         - receive framing-error strobe
//   is_transmitting_i    - UART transmitter busy
//   transmit_o, tx_byte_o - one-cycle send request and reply byte
//   cmd_valid_o, cmd_ready_i, cmd_id_o, cmd_angle_o - command handshake
//   err_count_o          - saturating count of NACKed frames
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int unsigned NUM_SERVOS     = 12,
  parameter int unsigned MAX_ANGLE      = 180,
  parameter int unsigned TIMEOUT_CYCLES = 5000000,
  parameter logic [7:0]  SYNC_BYTE      = SyncByte,
  parameter logic [7:0]  ACK_BYTE       = AckByte,
  parameter logic [7:0]  NACK_BYTE      = NackByte,
  localparam int unsigned IdW = (NUM_SERVOS > 1) ? $clog2(NUM_SERVOS) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           received_i,
  input  logic [7:0]     rx_byte_i,
  input  logic           recv_error_i,
  input  logic           is_transmitting_i,
  output logic           transmit_o,
  output logic [7:0]     tx_byte_o,
  output logic           cmd_valid_o,
  input  logic           cmd_ready_i,
  output logic [IdW-1:0] cmd_id_o,
  output logic [7:0]     cmd_angle_o,
  output logic [7:0]     err_count_o
);

  localparam logic [8:0] NumServosW = 9'(NUM_SERVOS);
  localparam logic [7:0] MaxAngleW  = 8'(MAX_ANGLE);

  state_e           state_q, state_d;
  logic [7:0]       id_q, id_d;
  logic [7:0]       ang_q, ang_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic [7:0]       err_q, err_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic [IdW-1:0]   cmd_id_q, cmd_id_d;
  logic [7:0]       cmd_angle_q, cmd_angle_d;
  logic             nack;
  logic             frame_ok;
  logic             timer_active;
  logic             timer_expired;

  assign timer_active = (state_q == StGetId) || (state_q == StGetAng) ||
                        (state_q == StGetCsum);

  cmd_timeout_timer #(
    .Timeout(TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (received_i | ~timer_active),
    .enable_i (timer_active),
    .expired_o(timer_expired)
  );

  assign frame_ok = (rx_byte_i == checksum(id_q, ang_q)) &&
                    ({1'b0, id_q} < NumServosW) && (ang_q <= MaxAngleW);

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    ang_d       = ang_q;
    tx_byte_d   = tx_byte_q;
    err_d       = err_q;
    cmd_valid_d = cmd_valid_q;
    cmd_id_d    = cmd_id_q;
    cmd_angle_d = cmd_angle_q;
    nack        = 1'b0;

    // Within a frame: recv_error beats a byte, and a byte beats the timeout.
    unique case (state_q)
      StIdle: begin
        if (received_i && (rx_byte_i == SYNC_BYTE)) state_d = StGetId;
      end
      StGetId: begin
        if (recv_error_i) begin
          nack = 1'b1;
        end else if (received_i) begin
          // A repeated sync is a resync; the timer restarts via the receive strobe.
          if (rx_byte_i != SYNC_BYTE) begin
            id_d    = rx_byte_i;
            state_d = StGetAng;
          end
        end else if (timer_expired) begin
          nack = 1'b1;
        end
      end
      StGetAng: begin
        if (recv_error_i) begin
          nack = 1'b1;
        end else if (received_i) begin
          ang_d   = rx_byte_i;
          state_d = StGetCsum;
        end else if (timer_expired) begin
          nack = 1'b1;
        end
      end
      StGetCsum: begin
        if (recv_error_i) begin
          nack = 1'b1;
        end else if (received_i) begin
          if (frame_ok) begin
            cmd_valid_d = 1'b1;
            cmd_id_d    = id_q[IdW-1:0];
            cmd_angle_d = ang_q;
            state_d     = StIssue;
          end else begin
            nack = 1'b1;
          end
        end else if (timer_expired) begin
          nack = 1'b1;
        end
      end
      StIssue: begin
        if (cmd_ready_i) begin
          cmd_valid_d = 1'b0;
          tx_byte_d   = ACK_BYTE;
          state_d     = StReply;
        end
      end
      StReply: begin
        if (!is_transmitting_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (nack) begin
      tx_byte_d = NACK_BYTE;
      state_d   = StReply;
      if (err_q != 8'hFF) err_d = err_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      id_q        <= '0;
      ang_q       <= '0;
      tx_byte_q   <= '0;
      err_q       <= '0;
      cmd_valid_q <= 1'b0;
      cmd_id_q    <= '0;
      cmd_angle_q <= '0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      ang_q       <= ang_d;
      tx_byte_q   <= tx_byte_d;
      err_q       <= err_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_id_q    <= cmd_id_d;
      cmd_angle_q <= cmd_angle_d;
    end
  end

  // The reply byte is loaded on entry to StReply, so it is already stable when the pulse fires.
  assign transmit_o  = (state_q == StReply) && !is_transmitting_i;
  assign tx_byte_o   = tx_byte_q;
  assign cmd_valid_o = cmd_valid_q;
  assign cmd_id_o    = cmd_id_q;
  assign cmd_angle_o = cmd_angle_q;
  assign err_count_o = err_q;

endmodule
